// File: rtl/cleveradder_iter_if.sv
// Operand/result handshake bundle for the iterative add/subtract unit.
// The design side uses the slave modport; the producer/consumer uses the master modport.
interface cleveradder_iter_if #(
  parameter int unsigned W = 2048
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         op_sub;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport slave (
    input  in_valid, a, b, c_in, op_sub, out_ready,
    output in_ready, sum, c_out, ovf, out_valid, busy
  );

  modport master (
    output in_valid, a, b, c_in, op_sub, out_ready,
    input  in_ready, sum, c_out, ovf, out_valid, busy
  );
endinterface

// File: rtl/cleveradder_iter.sv
// Iterative W-bit adder/subtractor: each BUSY cycle resolves K M-bit chunks with
// per-chunk carry-select and a registered carry between beats.
module cleveradder_iter #(
  parameter int unsigned W = 2048,
  parameter int unsigned M = 64,
  parameter int unsigned K = 4
) (
  input  logic             clk,
  input  logic             rst,
  cleveradder_iter_if.slave bus
);

  localparam int unsigned MK = M * K;
  localparam int unsigned NB = W / MK;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

  if ((W % MK) != 0 || NB < 1) begin : g_bad_params
    $error("cleveradder_iter: W must be a non-zero multiple of M*K");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic [BW-1:0]   r_beat;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_busy;
  logic            w_accept;
  logic            w_last;

  logic [MK-1:0]   w_sa;
  logic [MK-1:0]   w_sb;
  logic [MK-1:0]   w_ssum;
  logic [K:0]      w_c;
  logic            w_msb_cin;
  logic [M:0]      w_gsum [K];
  logic [M:0]      w_psum [K];

  assign w_sa   = r_a[r_beat * MK +: MK];
  assign w_sb   = r_b[r_beat * MK +: MK];
  assign w_last = (r_beat == BW'(NB - 1));

  // Both carry hypotheses per chunk; the real carry only picks between them.
  for (genvar k = 0; k < K; k++) begin : g_chunk
    assign w_gsum[k] = {1'b0, w_sa[k*M +: M]} + {1'b0, w_sb[k*M +: M]};
    assign w_psum[k] = {1'b0, w_sa[k*M +: M]} + {1'b0, w_sb[k*M +: M]} + (M+1)'(1);
  end

  always_comb begin
    w_c    = '0;
    w_ssum = '0;
    w_c[0] = r_carry;
    for (int unsigned k = 0; k < K; k++) begin
      if (w_c[k]) begin
        w_ssum[k*M +: M] = w_psum[k][M-1:0];
        w_c[k+1]         = w_psum[k][M];
      end else begin
        w_ssum[k*M +: M] = w_gsum[k][M-1:0];
        w_c[k+1]         = w_gsum[k][M];
      end
    end
  end

  // Carry into the top bit of the slice, recovered from its sum and operand bits.
  assign w_msb_cin = w_ssum[MK-1] ^ w_sa[MK-1] ^ w_sb[MK-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = rst;
        w_accept   = bus.in_valid && w_in_ready;
        if (w_accept) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_beat  <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= bus.op_sub ? ~bus.b : bus.b;
        r_carry <= bus.c_in;
        r_beat  <= '0;
      end else if (r_state == S_BUSY) begin
        r_sum[r_beat * MK +: MK] <= w_ssum;
        r_carry <= w_c[K];
        r_beat  <= r_beat + BW'(1);
        if (w_last) begin
          r_cout <= w_c[K];
          r_ovf  <= w_msb_cin ^ w_c[K];
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_cleveradder_iter.sv
// Directed and randomized checks of cleveradder_iter at W=16 (NB=2 and NB=1 builds).
module tb_cleveradder_iter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cleveradder_iter_if #(.W(16)) if2 ();
  cleveradder_iter_if #(.W(16)) if1 ();

  cleveradder_iter #(.W(16), .M(4), .K(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  cleveradder_iter #(.W(16), .M(16), .K(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] cap_sum;
  logic        cap_cout;
  logic        cap_ovf;
  int          lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] be;
    logic [16:0] t;
    logic        v;
    be = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + 17'(cin);
    v  = (a[15] == be[15]) && (t[15] != a[15]);
    return {v, t};
  endfunction

  // Handshake one operation into the NB=2 build, scramble inputs while it works,
  // and capture the result on the first out_valid cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    bit acc;
    acc = 1'b0;
    if2.a = a; if2.b = b; if2.c_in = cin; if2.op_sub = sub;
    if2.in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = if2.in_ready;
      tick();
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    if2.a = ~a; if2.b = ~b; if2.c_in = ~cin; if2.op_sub = ~sub;
    lat = 0;
    while (!if2.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    cap_sum  = if2.sum;
    cap_cout = if2.c_out;
    cap_ovf  = if2.ovf;
  endtask

  task automatic finish_op(input bit rand_ready);
    bit hs;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      if2.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = if2.out_ready;
      tick();
      if (!hs) chk("stall_sum", 32'(if2.sum), 32'(cap_sum));
    end
    if (!hs) begin
      if2.out_ready = 1'b1;
      tick();
    end
    if2.in_valid  = 1'b0;
    if2.out_ready = 1'b1;
    chk("hs_clear", 32'(if2.out_valid), 32'd0);
  endtask

  task automatic check_exp(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub);
    logic [17:0] e;
    e = model(a, b, cin, sub);
    chk({tag, "_sum"},  32'(cap_sum),  32'(e[15:0]));
    chk({tag, "_cout"}, 32'(cap_cout), 32'(e[16]));
    chk({tag, "_ovf"},  32'(cap_ovf),  32'(e[17]));
    chk({tag, "_lat"},  32'(lat),      32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rs;

    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.c_in = 1'b0; if2.op_sub = 1'b0;
    if2.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.c_in = 1'b0; if1.op_sub = 1'b0;
    if1.out_ready = 1'b1;

    #2;
    chk("rst_in_ready",  32'(if2.in_ready),  32'd0);
    chk("rst_out_valid", 32'(if2.out_valid), 32'd0);
    chk("rst_busy",      32'(if2.busy),      32'd0);
    chk("rst_sum",       32'(if2.sum),       32'd0);
    #20 rst = 1'b1;
    tick();
    chk("idle_in_ready", 32'(if2.in_ready), 32'd1);

    // Test 1: all-ones + 1 wraps to zero with carry out
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("t1_sum",  32'(cap_sum),  32'h0000);
    chk("t1_cout", 32'(cap_cout), 32'd1);
    chk("t1_ovf",  32'(cap_ovf),  32'd0);
    chk("t1_lat",  32'(lat),      32'd2);
    chk("t1_busy", 32'(if2.busy), 32'd1);
    finish_op(1'b0);
    chk("t1_rdy_after", 32'(if2.in_ready), 32'd1);

    // Test 2: signed overflow, then subtraction with borrow
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("t2_sum",  32'(cap_sum),  32'h8000);
    chk("t2_cout", 32'(cap_cout), 32'd0);
    chk("t2_ovf",  32'(cap_ovf),  32'd1);
    finish_op(1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    chk("t2s_sum",  32'(cap_sum),  32'hFFFE);
    chk("t2s_cout", 32'(cap_cout), 32'd0);
    chk("t2s_ovf",  32'(cap_ovf),  32'd0);
    finish_op(1'b0);

    // Test 3: back-pressure holds the result (0x8000+0x8001 -> 0x0001, carry, overflow)
    if2.out_ready = 1'b0;
    run_op(16'h8000, 16'h8001, 1'b0, 1'b0);
    chk("t3_sum",  32'(cap_sum),  32'h0001);
    chk("t3_cout", 32'(cap_cout), 32'd1);
    chk("t3_ovf",  32'(cap_ovf),  32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", 32'(if2.out_valid), 32'd1);
      chk("t3_hold_sum",   32'(if2.sum),       32'h0001);
      chk("t3_hold_rdy",   32'(if2.in_ready),  32'd0);
    end
    if2.out_ready = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    chk("t3_release_valid", 32'(if2.out_valid), 32'd0);
    chk("t3_release_rdy",   32'(if2.in_ready),  32'd1);

    // Test 4: asynchronous reset during beat 1 aborts the operation
    if2.a = 16'h4321; if2.b = 16'h1111; if2.c_in = 1'b0; if2.op_sub = 1'b0;
    if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    tick();
    chk("t4_busy_pre", 32'(if2.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t4_rst_busy",   32'(if2.busy),      32'd0);
    chk("t4_rst_valid",  32'(if2.out_valid), 32'd0);
    chk("t4_rst_rdy",    32'(if2.in_ready),  32'd0);
    chk("t4_rst_sum",    32'(if2.sum),       32'd0);
    chk("t4_rst_cout",   32'(if2.c_out),     32'd0);
    chk("t4_rst_ovf",    32'(if2.ovf),       32'd0);
    tick();
    tick();
    #3 rst = 1'b1;
    tick();
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    chk("t4_fresh_sum", 32'(cap_sum), 32'h2345);
    chk("t4_fresh_lat", 32'(lat),     32'd2);
    finish_op(1'b0);

    // Test 6: single-beat build
    if1.a = 16'hABCD; if1.b = 16'h5433; if1.c_in = 1'b0; if1.op_sub = 1'b0;
    chk("t6_rdy", 32'(if1.in_ready), 32'd1);
    if1.in_valid = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    chk("t6_busy", 32'(if1.busy), 32'd1);
    lat = 0;
    while (!if1.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("t6_lat",  32'(lat),        32'd1);
    chk("t6_sum",  32'(if1.sum),    32'h0000);
    chk("t6_cout", 32'(if1.c_out),  32'd1);
    chk("t6_ovf",  32'(if1.ovf),    32'd0);
    tick();
    chk("t6_idle", 32'(if1.in_ready), 32'd1);

    // Randomized traffic against the reference model with random gaps and stalls
    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      run_op(ra, rb, rc, rs);
      check_exp("rnd", ra, rb, rc, rs);
      finish_op(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
